// File: rtl/pixel_source_arbiter.sv
// rtl/pixel_source_arbiter.sv - frame-synchronous pixel source selector with 2-stage SDRAM word packing; split screen built when ARB_SPLIT_SCREEN_EN is defined
module pixel_source_arbiter #(
  parameter int          NUM_CH   = 5,
  parameter int          SEL_W    = 3,
  parameter int          XY_W     = 16,
  parameter int          SPLIT_X  = 640,
  parameter logic [29:0] FILL_RGB = 30'h3FF00000
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iFval,
  input  logic [SEL_W-1:0]       iSelA,
  input  logic [SEL_W-1:0]       iSelB,
  input  logic                   iSplit,
  input  logic [XY_W-1:0]        iX_Cont,
  input  logic [XY_W-1:0]        iY_Cont,
  input  logic [NUM_CH*30-1:0]   iPix,
  input  logic [NUM_CH-1:0]      iValid,
  output logic [15:0]            oWr1_data,
  output logic [15:0]            oWr2_data,
  output logic                   oWr_data_valid,
  output logic [SEL_W-1:0]       oSel_active,
  output logic [15:0]            oFrame_cnt
);

  logic [SEL_W-1:0] selA_q, selA_d;
  logic [SEL_W-1:0] sel_eff;
  logic [29:0]      pix1_q, pix1_d;
  logic             val1_q, val1_d;
  logic [15:0]      wr1_q, wr1_d, wr2_q, wr2_d;
  logic             wrv_q;
  logic             fval_q;
  logic [15:0]      cnt_q, cnt_d;

  // Primary select only follows the switches during blanking
  always_comb begin
    selA_d = iFval ? selA_q : iSelA;
  end

  // Primary shadow select register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) selA_q <= '0;
    else      selA_q <= selA_d;
  end

`ifdef ARB_SPLIT_SCREEN_EN
  logic [SEL_W-1:0] selB_q, selB_d;
  logic             split_q, split_d;
  logic             right_half;
  logic             unused_in;

  assign right_half = (iX_Cont >= XY_W'(SPLIT_X));
  assign unused_in  = ^iY_Cont;

  // Secondary select and split request share the blanking-only load rule
  always_comb begin
    selB_d  = iFval ? selB_q  : iSelB;
    split_d = iFval ? split_q : iSplit;
  end

  // Secondary shadow registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      selB_q  <= '0;
      split_q <= 1'b0;
    end else begin
      selB_q  <= selB_d;
      split_q <= split_d;
    end
  end

  assign sel_eff = (split_q && right_half) ? selB_q : selA_q;
`else
  logic unused_in;
  assign unused_in = ^{iY_Cont, iSelB, iSplit, iX_Cont};
  assign sel_eff   = selA_q;
`endif

  // Decode the effective select into a pixel; out-of-range selects give the fill colour
  always_comb begin
    logic hit;
    hit    = 1'b0;
    pix1_d = FILL_RGB;
    val1_d = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_eff == SEL_W'(k + 1)) begin
        hit    = 1'b1;
        pix1_d = iPix[30*k +: 30];
        val1_d = iValid[k] & iFval;
      end
    end
    if (hit && !val1_d) pix1_d = '0;
  end

  // Pack stage-1 pixel into the two SDRAM words: {0,G[9:5],B} and {0,G[4:0],R}
  always_comb begin
    wr1_d = {1'b0, pix1_q[19:15], pix1_q[9:0]};
    wr2_d = {1'b0, pix1_q[14:10], pix1_q[29:20]};
  end

  // Two-stage pixel pipeline
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pix1_q <= '0;
      val1_q <= 1'b0;
      wr1_q  <= '0;
      wr2_q  <= '0;
      wrv_q  <= 1'b0;
    end else begin
      pix1_q <= pix1_d;
      val1_q <= val1_d;
      wr1_q  <= wr1_d;
      wr2_q  <= wr2_d;
      wrv_q  <= val1_q;
    end
  end

  // Count completed frames on each falling edge of frame valid
  always_comb begin
    cnt_d = (fval_q && !iFval) ? cnt_q + 16'd1 : cnt_q;
  end

  // Frame valid history and frame counter
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      fval_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      fval_q <= iFval;
      cnt_q  <= cnt_d;
    end
  end

  assign oWr1_data      = wr1_q;
  assign oWr2_data      = wr2_q;
  assign oWr_data_valid = wrv_q;
  assign oSel_active    = selA_q;
  assign oFrame_cnt     = cnt_q;

endmodule

// File: tb/tb_pixel_source_arbiter.sv
// tb/tb_pixel_source_arbiter.sv - directed and randomized self-checking bench for pixel_source_arbiter
`timescale 1ns/1ps
module tb_pixel_source_arbiter;

`ifdef ARB_SPLIT_SCREEN_EN
  localparam bit SPLIT_ON = 1'b1;
`else
  localparam bit SPLIT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fval = 1'b0;
  logic [2:0]   sel_a = '0, sel_b = '0;
  logic         split = 1'b0;
  logic [15:0]  x = '0, y = '0;
  logic [149:0] pix = '0;
  logic [4:0]   valid = '0;
  logic [15:0]  wr1, wr2, cnt;
  logic         wrv;
  logic [2:0]   sel_act;

  int n_pass = 0;
  int n_total = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pixel_source_arbiter dut (
    .iClk(clk), .iRst(rst), .iFval(fval), .iSelA(sel_a), .iSelB(sel_b),
    .iSplit(split), .iX_Cont(x), .iY_Cont(y), .iPix(pix), .iValid(valid),
    .oWr1_data(wr1), .oWr2_data(wr2), .oWr_data_valid(wrv),
    .oSel_active(sel_act), .oFrame_cnt(cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pack1(logic [29:0] p);
    logic [9:0] g, b;
    g = p[19:10]; b = p[9:0];
    return {1'b0, g[9:5], b};
  endfunction

  function automatic logic [15:0] pack2(logic [29:0] p);
    logic [9:0] r, g;
    r = p[29:20]; g = p[19:10];
    return {1'b0, g[4:0], r};
  endfunction

  // Reference: choose source by the select rules, then pack; {valid, wr1, wr2}
  function automatic logic [32:0] model(int a, int b, logic s, int xc, logic f,
                                        logic [149:0] p, logic [4:0] v);
    int sel;
    logic [29:0] px;
    logic vo;
    sel = a;
    if (SPLIT_ON && s && xc >= 640) sel = b;
    if (sel < 1 || sel > 5) begin
      px = 30'h3FF00000; vo = 1'b0;
    end else begin
      px = p[30*(sel-1) +: 30];
      vo = v[sel-1] & f;
      if (!vo) px = '0;
    end
    return {vo, pack1(px), pack2(px)};
  endfunction

  task automatic test_reset();
    #2;
    n_total++; if (wr1 !== 16'h0) $display("FAIL reset_wr1 got %h exp 0000", wr1); else n_pass++;
    n_total++; if (wr2 !== 16'h0) $display("FAIL reset_wr2 got %h exp 0000", wr2); else n_pass++;
    n_total++; if (wrv !== 1'b0) $display("FAIL reset_valid got %b exp 0", wrv); else n_pass++;
    n_total++; if (sel_act !== 3'd0) $display("FAIL reset_sel got %0d exp 0", sel_act); else n_pass++;
    n_total++; if (cnt !== 16'h0) $display("FAIL reset_cnt got %0d exp 0", cnt); else n_pass++;
  endtask

  task automatic test_fill_default();
    tick();
    rst = 1'b0; sel_a = 3'd0; fval = 1'b0;
    tick(); tick();
    n_total++; if (wr1 !== 16'h0000) $display("FAIL fill_wr1 got %h exp 0000", wr1); else n_pass++;
    n_total++; if (wr2 !== 16'h03FF) $display("FAIL fill_wr2 got %h exp 03FF", wr2); else n_pass++;
    n_total++; if (wrv !== 1'b0) $display("FAIL fill_valid got %b exp 0", wrv); else n_pass++;
  endtask

  task automatic test_select_channel();
    sel_a = 3'd1; fval = 1'b0;
    tick();
    fval = 1'b1; valid = 5'b00001; pix[29:0] = {10'h000, 10'h3FF, 10'h3C3};
    tick(); tick();
    n_total++; if (wr1 !== 16'h7FC3) $display("FAIL ch0_wr1 got %h exp 7FC3", wr1); else n_pass++;
    n_total++; if (wr2 !== 16'h7C00) $display("FAIL ch0_wr2 got %h exp 7C00", wr2); else n_pass++;
    n_total++; if (wrv !== 1'b1) $display("FAIL ch0_valid got %b exp 1", wrv); else n_pass++;
    n_total++; if (sel_act !== 3'd1) $display("FAIL ch0_sel got %0d exp 1", sel_act); else n_pass++;
  endtask

  task automatic test_deferred_switch();
    logic [29:0] p1;
    p1 = {10'h00F, 10'h00F, 10'h00F};
    sel_a = 3'd2; pix[59:30] = p1; valid = 5'b00011;
    tick(); tick();
    n_total++; if (wr1 !== 16'h7FC3) $display("FAIL defer_wr1 got %h exp 7FC3", wr1); else n_pass++;
    n_total++; if (wr2 !== 16'h7C00) $display("FAIL defer_wr2 got %h exp 7C00", wr2); else n_pass++;
    n_total++; if (sel_act !== 3'd1) $display("FAIL defer_sel got %0d exp 1", sel_act); else n_pass++;
    fval = 1'b0; exp_cnt++;
    tick();
    fval = 1'b1;
    tick(); tick();
    n_total++; if (wr1 !== pack1(p1)) $display("FAIL switch_wr1 got %h exp %h", wr1, pack1(p1)); else n_pass++;
    n_total++; if (wr2 !== pack2(p1)) $display("FAIL switch_wr2 got %h exp %h", wr2, pack2(p1)); else n_pass++;
    n_total++; if (sel_act !== 3'd2) $display("FAIL switch_sel got %0d exp 2", sel_act); else n_pass++;
    n_total++; if (cnt !== 16'(exp_cnt)) $display("FAIL switch_cnt got %0d exp %0d", cnt, exp_cnt); else n_pass++;
  endtask

  task automatic test_invalid_select();
    fval = 1'b0; sel_a = 3'd6;
    tick();
    fval = 1'b1; valid = 5'b11111;
    tick(); tick();
    n_total++; if (wr1 !== 16'h0000) $display("FAIL sel6_wr1 got %h exp 0000", wr1); else n_pass++;
    n_total++; if (wr2 !== 16'h03FF) $display("FAIL sel6_wr2 got %h exp 03FF", wr2); else n_pass++;
    n_total++; if (wrv !== 1'b0) $display("FAIL sel6_valid got %b exp 0", wrv); else n_pass++;
    fval = 1'b0; sel_a = 3'd1;
    tick();
    fval = 1'b1; valid = 5'b11110; pix[29:0] = 30'h2AAAAAAA;
    tick(); tick();
    n_total++; if ({wrv, wr1, wr2} !== 33'h0) $display("FAIL black_out got %b/%h/%h exp 0/0000/0000", wrv, wr1, wr2); else n_pass++;
  endtask

  task automatic test_fval_rise_select();
    fval = 1'b0; sel_a = 3'd1; valid = 5'b11111; pix = {5{30'h12345678}};
    pix[29:0] = 30'h0ABCDEF1;
    tick();
    fval = 1'b1; sel_a = 3'd3;
    tick(); tick();
    n_total++; if (sel_act !== 3'd1) $display("FAIL rise_sel got %0d exp 1", sel_act); else n_pass++;
    n_total++; if (wr1 !== pack1(30'h0ABCDEF1)) $display("FAIL rise_wr1 got %h exp %h", wr1, pack1(30'h0ABCDEF1)); else n_pass++;
  endtask

  task automatic test_split();
    logic [29:0] pa, pb, pexp;
    pa = 30'($urandom); pb = 30'($urandom);
    fval = 1'b0; sel_a = 3'd1; sel_b = 3'd2; split = 1'b1;
    tick();
    fval = 1'b1; valid = 5'b11111; pix[29:0] = pa; pix[59:30] = pb; x = 16'd639;
    tick();
    x = 16'd640;
    tick();
    n_total++; if (wr1 !== pack1(pa) || wr2 !== pack2(pa)) $display("FAIL split_x639 got %h/%h exp %h/%h", wr1, wr2, pack1(pa), pack2(pa)); else n_pass++;
    tick();
    pexp = SPLIT_ON ? pb : pa;
    n_total++; if (wr1 !== pack1(pexp) || wr2 !== pack2(pexp)) $display("FAIL split_x640 got %h/%h exp %h/%h", wr1, wr2, pack1(pexp), pack2(pexp)); else n_pass++;
    split = 1'b0; x = '0;
  endtask

  task automatic test_random();
    int ma, mb, mcnt;
    logic ms, mf;
    logic [32:0] q[$];
    logic [32:0] e;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ma = 0; mb = 0; ms = 1'b0; mf = 1'b0; mcnt = 0;
    q.delete();
    q.push_back(33'h0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) fval = ~fval;
      sel_a = 3'($urandom_range(0, 7));
      sel_b = 3'($urandom_range(0, 7));
      split = 1'($urandom_range(0, 1));
      x = 16'($urandom_range(636, 644));
      y = 16'($urandom);
      valid = 5'($urandom);
      for (int k = 0; k < 5; k++) pix[30*k +: 30] = 30'($urandom);
      q.push_back(model(ma, mb, ms, int'(x), fval, pix, valid));
      @(posedge clk);
      if (!fval) begin ma = int'(sel_a); mb = int'(sel_b); ms = split; end
      if (mf && !fval) mcnt = (mcnt + 1) % 65536;
      mf = fval;
      #1;
      e = q.pop_front();
      n_total++; if (wrv !== e[32]) $display("FAIL rand_valid cyc %0d got %b exp %b", i, wrv, e[32]); else n_pass++;
      n_total++; if (wr1 !== e[31:16]) $display("FAIL rand_wr1 cyc %0d got %h exp %h", i, wr1, e[31:16]); else n_pass++;
      n_total++; if (wr2 !== e[15:0]) $display("FAIL rand_wr2 cyc %0d got %h exp %h", i, wr2, e[15:0]); else n_pass++;
      n_total++; if (int'(sel_act) != ma) $display("FAIL rand_sel cyc %0d got %0d exp %0d", i, sel_act, ma); else n_pass++;
      n_total++; if (int'(cnt) != mcnt) $display("FAIL rand_cnt cyc %0d got %0d exp %0d", i, cnt, mcnt); else n_pass++;
    end
  endtask

  task automatic test_frame_cnt_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0; fval = 1'b0; sel_a = 3'd1; valid = 5'b11111; pix[29:0] = 30'h3FFFFFFF;
    tick();
    for (int f = 0; f < 3; f++) begin
      fval = 1'b1; tick(); tick(); tick();
      fval = 1'b0; tick(); tick();
    end
    fval = 1'b1;
    tick(); tick(); tick();
    n_total++; if (cnt !== 16'd3) $display("FAIL frames_cnt got %0d exp 3", cnt); else n_pass++;
    n_total++; if (wrv !== 1'b1) $display("FAIL frames_valid got %b exp 1", wrv); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if ({wr1, wr2, wrv, sel_act, cnt} !== 52'h0) $display("FAIL async_reset got %h/%h/%b/%0d/%0d exp all 0", wr1, wr2, wrv, sel_act, cnt); else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_default();
    test_select_channel();
    test_deferred_switch();
    test_invalid_select();
    test_fval_rise_select();
    test_split();
    test_random();
    test_frame_cnt_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
